reaction_trial_sequencer: RTL and testbench

Sequences a multi-trial reaction test on top of the reaction datapath: countdown, counter and score latch, with PRNG delay owned by the datapath.
- Runs NUM_TRIALS rounds and handles false starts and timeouts.
- Accumulates trial times and computes the session average with an iterative divider.
- Tracks the best (lowest) session average.
- Sits between keyboard-decoded key levels and the datapath; its screen code goes to the VGA renderer.

---
 rtl/reaction_trial_sequencer_pkg.sv | 26 ++
 rtl/reaction_trial_sequencer_if.sv | 31 +++
 rtl/reaction_trial_sequencer_seq_divider.sv | 59 +++++
 rtl/reaction_trial_sequencer.sv | 139 +++++++++++++
 tb/tb_reaction_trial_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reaction_trial_sequencer_pkg.sv
// Shared definitions for the reaction trial sequencer: screen codes, FSM state and widths.
// The state encoding matches the screen code so the state register drives the renderer directly.
package reaction_trial_sequencer_pkg;

    localparam int SCORE_W = 14;
    localparam int SUM_W   = SCORE_W + 3;

    localparam logic [2:0] SCR_TITLE   = 3'd0;
    localparam logic [2:0] SCR_WAIT    = 3'd1;
    localparam logic [2:0] SCR_GO      = 3'd2;
    localparam logic [2:0] SCR_RESULT  = 3'd3;
    localparam logic [2:0] SCR_FALSE   = 3'd4;
    localparam logic [2:0] SCR_BUSY    = 3'd5;
    localparam logic [2:0] SCR_SUMMARY = 3'd6;

    typedef enum logic [2:0] {
        ST_TITLE   = SCR_TITLE,
        ST_WAIT    = SCR_WAIT,
        ST_GO      = SCR_GO,
        ST_RESULT  = SCR_RESULT,
        ST_FALSE   = SCR_FALSE,
        ST_BUSY    = SCR_BUSY,
        ST_SUMMARY = SCR_SUMMARY
    } seqStateT;

endpackage

// File: rtl/reaction_trial_sequencer_if.sv
// Key levels and datapath status in, datapath control and renderer/score values out.
interface reaction_trial_sequencer_if;
    import reaction_trial_sequencer_pkg::*;

    logic               spacePressed;
    logic               onePressed;
    logic               downCountComplete;
    logic [SCORE_W-1:0] iElapsed;

    logic [2:0]         screen;
    logic               startDownCount;
    logic               startUpCount;
    logic               loadScore;
    logic [2:0]         trialIndex;
    logic [SCORE_W-1:0] lastScore;
    logic [SCORE_W-1:0] avgScore;
    logic [SCORE_W-1:0] bestAvg;

    modport master (
        input  spacePressed, onePressed, downCountComplete, iElapsed,
        output screen, startDownCount, startUpCount, loadScore,
               trialIndex, lastScore, avgScore, bestAvg
    );

    modport slave (
        output spacePressed, onePressed, downCountComplete, iElapsed,
        input  screen, startDownCount, startUpCount, loadScore,
               trialIndex, lastScore, avgScore, bestAvg
    );

endinterface

// File: rtl/reaction_trial_sequencer_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; done pulses SUM_W cycles after start.
module seq_divider
    import reaction_trial_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             iReset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [2:0]       divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int CNT_W = $clog2(SUM_W + 1);

    logic [2:0]       remReg;
    logic [SUM_W-1:0] quoReg;
    logic [CNT_W-1:0] countReg;
    logic             busyReg;
    logic             doneReg;
    logic [3:0]       shifted;
    logic             fits;

    // Dividend bits shift out of the top of quoReg while quotient bits shift in at the bottom.
    always_comb begin
        shifted = {remReg, quoReg[SUM_W-1]};
        fits    = (shifted >= {1'b0, divisor});
    end

    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            remReg   <= '0;
            quoReg   <= '0;
            countReg <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (start) begin
                remReg   <= '0;
                quoReg   <= dividend;
                countReg <= CNT_W'(SUM_W);
                busyReg  <= 1'b1;
            end else if (busyReg) begin
                remReg   <= 3'(fits ? shifted - {1'b0, divisor} : shifted);
                quoReg   <= {quoReg[SUM_W-2:0], fits};
                countReg <= countReg - 1'b1;
                if (countReg == CNT_W'(1)) begin
                    busyReg <= 1'b0;
                    doneReg <= 1'b1;
                end
            end
        end
    end

    assign done     = doneReg;
    assign quotient = quoReg;

endmodule

// File: rtl/reaction_trial_sequencer.sv
// Multi-trial reaction test sequencer: drives the datapath, records trial times,
// averages each session through seq_divider and keeps the best session average.
module reaction_trial_sequencer
    import reaction_trial_sequencer_pkg::*;
#(
    parameter int NUM_TRIALS = 5,
    parameter int MAX_MS     = 9999
) (
    input  logic                         clk,
    input  logic                         iReset,
    reaction_trial_sequencer_if.master   bus
);

    seqStateT           stateReg, stateNext;
    logic [1:0]         keyLevel, keyPrevReg, keyEdgeReg;
    logic               spaceEdge, oneEdge;
    logic [SUM_W-1:0]   sumReg, quotient;
    logic [2:0]         trialIndexReg;
    logic [SCORE_W-1:0] lastScoreReg, avgScoreReg, bestAvgReg, recordedScore;
    logic               timeout, lastTrial, divStart, divDone;
    logic               startDownCount, startUpCount, loadScore;

    assign keyLevel  = {bus.onePressed, bus.spacePressed};
    assign spaceEdge = keyEdgeReg[0];
    assign oneEdge   = keyEdgeReg[1];

    // Previous-level samples reset high so a key still held through reset must be
    // released and pressed again before it counts.
    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            keyPrevReg <= 2'b11;
            keyEdgeReg <= 2'b00;
        end else begin
            keyPrevReg <= keyLevel;
            keyEdgeReg <= keyLevel & ~keyPrevReg;
        end
    end

    assign timeout       = (bus.iElapsed >= SCORE_W'(MAX_MS));
    assign lastTrial     = (trialIndexReg == 3'(NUM_TRIALS - 1));
    assign recordedScore = spaceEdge ? bus.iElapsed : SCORE_W'(MAX_MS);

    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) stateReg <= ST_TITLE;
        else         stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        if (oneEdge) begin
            stateNext = ST_TITLE;
        end else begin
            case (stateReg)
                ST_TITLE:   if (spaceEdge) stateNext = ST_WAIT;
                ST_WAIT: begin
                    if (spaceEdge)                  stateNext = ST_FALSE;
                    else if (bus.downCountComplete) stateNext = ST_GO;
                end
                ST_GO:      if (spaceEdge || timeout) stateNext = ST_RESULT;
                ST_FALSE:   if (spaceEdge) stateNext = ST_WAIT;
                ST_RESULT:  if (spaceEdge) stateNext = lastTrial ? ST_BUSY : ST_WAIT;
                ST_BUSY:    if (divDone) stateNext = ST_SUMMARY;
                ST_SUMMARY: if (spaceEdge) stateNext = ST_WAIT;
                default:    stateNext = ST_TITLE;
            endcase
        end
    end

    // Strobes are Mealy outputs of the transition cycle, so each lasts exactly one clock.
    always_comb begin
        startDownCount = 1'b0;
        startUpCount   = 1'b0;
        loadScore      = 1'b0;
        divStart       = 1'b0;
        if (!oneEdge) begin
            case (stateReg)
                ST_TITLE, ST_FALSE, ST_SUMMARY: startDownCount = spaceEdge;
                ST_WAIT:   startUpCount = !spaceEdge && bus.downCountComplete;
                ST_GO:     loadScore    = spaceEdge || timeout;
                ST_RESULT: begin
                    startDownCount = spaceEdge && !lastTrial;
                    divStart       = spaceEdge && lastTrial;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            sumReg        <= '0;
            trialIndexReg <= '0;
            lastScoreReg  <= '0;
            avgScoreReg   <= '0;
            bestAvgReg    <= '0;
        end else begin
            if (oneEdge && stateReg != ST_TITLE) begin
                sumReg        <= '0;
                trialIndexReg <= '0;
            end
            if (startDownCount && (stateReg == ST_TITLE || stateReg == ST_SUMMARY)) begin
                sumReg        <= '0;
                trialIndexReg <= '0;
            end
            if (startDownCount && stateReg == ST_RESULT)
                trialIndexReg <= trialIndexReg + 3'd1;
            if (loadScore) begin
                lastScoreReg <= recordedScore;
                sumReg       <= sumReg + SUM_W'(recordedScore);
            end
            // A late done after an abort to TITLE is ignored because the state is no longer BUSY.
            if (divDone && stateReg == ST_BUSY && !oneEdge) begin
                avgScoreReg <= quotient[SCORE_W-1:0];
                if (bestAvgReg == '0 || quotient < SUM_W'(bestAvgReg))
                    bestAvgReg <= quotient[SCORE_W-1:0];
            end
        end
    end

    seq_divider uDivider (
        .clk      (clk),
        .iReset   (iReset),
        .start    (divStart),
        .dividend (sumReg),
        .divisor  (3'(NUM_TRIALS)),
        .done     (divDone),
        .quotient (quotient)
    );

    assign bus.screen         = stateReg;
    assign bus.startDownCount = startDownCount;
    assign bus.startUpCount   = startUpCount;
    assign bus.loadScore      = loadScore;
    assign bus.trialIndex     = trialIndexReg;
    assign bus.lastScore      = lastScoreReg;
    assign bus.avgScore       = avgScoreReg;
    assign bus.bestAvg        = bestAvgReg;

endmodule

// File: tb/tb_reaction_trial_sequencer.sv
// Directed bench for reaction_trial_sequencer: full sessions, false start, timeouts,
// best-average tracking, simultaneous events and asynchronous reset, with a lastScore scoreboard.
`timescale 1ns/1ps
module tb_reaction_trial_sequencer;
    import reaction_trial_sequencer_pkg::*;

    localparam int NT    = 5;
    localparam int MAXMS = 9999;

    logic clk = 1'b0;
    logic iReset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    reaction_trial_sequencer_if bus();

    reaction_trial_sequencer #(.NUM_TRIALS(NT), .MAX_MS(MAXMS)) dut (
        .clk    (clk),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   expQ[$];
    int   pendingExp = 0;
    logic pendingLoad = 1'b0;
    int   expSum = 0;
    int   expBest = 0;
    int   sc[NT];
    logic capDown, capUp, capLoad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every loadScore strobe must match a queued score, which lastScore shows next cycle.
    always @(negedge clk) begin
        #2;
        if (pendingLoad) begin
            check("lastScore", 32'(bus.lastScore), 32'(pendingExp));
            $display("load: lastScore=%0d expected=%0d", bus.lastScore, pendingExp);
            pendingLoad = 1'b0;
        end
        if (bus.loadScore === 1'b1) begin
            if (expQ.size() == 0) check("loadScore unexpected", 32'(bus.loadScore), 32'd0);
            else begin
                pendingExp  = expQ.pop_front();
                pendingLoad = 1'b1;
            end
        end
    end

    task automatic pressSpace();
        @(negedge clk); bus.spacePressed = 1'b1;
        @(negedge clk); #1;
        capDown = bus.startDownCount;
        capUp   = bus.startUpCount;
        capLoad = bus.loadScore;
        bus.spacePressed = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic fireDcc();
        @(negedge clk); bus.downCountComplete = 1'b1; #1;
        capUp = bus.startUpCount;
        @(negedge clk); bus.downCountComplete = 1'b0; #1;
    endtask

    task automatic startSession();
        pressSpace();
        check("session startDownCount", 32'(capDown), 32'd1);
        check("session screen WAIT", 32'(bus.screen), 32'(SCR_WAIT));
        check("session trialIndex", 32'(bus.trialIndex), 32'd0);
        expSum = 0;
    endtask

    task automatic doTrial(input int el, input int idx);
        fireDcc();
        check("startUpCount", 32'(capUp), 32'd1);
        check("screen GO", 32'(bus.screen), 32'(SCR_GO));
        if (el >= MAXMS) begin
            @(negedge clk);
            expQ.push_back(MAXMS);
            expSum += MAXMS;
            bus.iElapsed = 14'(el);
            @(negedge clk); #1;
        end else begin
            bus.iElapsed = 14'(el);
            expQ.push_back(el);
            expSum += el;
            pressSpace();
            check("loadScore on press", 32'(capLoad), 32'd1);
            check("loadScore width", 32'(bus.loadScore), 32'd0);
        end
        check("screen RESULT", 32'(bus.screen), 32'(SCR_RESULT));
        check("trialIndex in RESULT", 32'(bus.trialIndex), 32'(idx));
        bus.iElapsed = '0;
        $display("trial %0d: elapsed=%0d screen=%0d", idx, el, bus.screen);
    endtask

    task automatic runTrials(input int falseAt);
        for (int i = 0; i < NT; i++) begin
            if (i == falseAt) begin
                pressSpace();
                check("false screen", 32'(bus.screen), 32'(SCR_FALSE));
                check("false no loadScore", 32'(capLoad), 32'd0);
                check("false trialIndex", 32'(bus.trialIndex), 32'(i));
                pressSpace();
                check("retry startDownCount", 32'(capDown), 32'd1);
                check("retry screen WAIT", 32'(bus.screen), 32'(SCR_WAIT));
                $display("false start at trial %0d", i);
            end
            doTrial(sc[i], i);
            pressSpace();
            if (i < NT - 1) begin
                check("next startDownCount", 32'(capDown), 32'd1);
                check("next screen WAIT", 32'(bus.screen), 32'(SCR_WAIT));
                check("next trialIndex", 32'(bus.trialIndex), 32'(i + 1));
            end else begin
                check("last no startDownCount", 32'(capDown), 32'd0);
                check("screen BUSY", 32'(bus.screen), 32'(SCR_BUSY));
            end
        end
    endtask

    task automatic finishSession();
        int cnt;
        int expAvg;
        cnt = 0;
        while (bus.screen == SCR_BUSY && cnt < 100) begin
            @(negedge clk); #1;
            cnt++;
        end
        expAvg = expSum / NT;
        if (expBest == 0 || expAvg < expBest) expBest = expAvg;
        check("BUSY cycles", 32'(cnt), 32'd18);
        check("screen SUMMARY", 32'(bus.screen), 32'(SCR_SUMMARY));
        check("avgScore", 32'(bus.avgScore), 32'(expAvg));
        check("bestAvg", 32'(bus.bestAvg), 32'(expBest));
        $display("session: sum=%0d avg=%0d best=%0d busy=%0d", expSum, bus.avgScore, bus.bestAvg, cnt);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " screen"}, 32'(bus.screen), 32'd0);
        check({tag, " trialIndex"}, 32'(bus.trialIndex), 32'd0);
        check({tag, " lastScore"}, 32'(bus.lastScore), 32'd0);
        check({tag, " avgScore"}, 32'(bus.avgScore), 32'd0);
        check({tag, " bestAvg"}, 32'(bus.bestAvg), 32'd0);
        check({tag, " pulses"}, 32'({bus.startDownCount, bus.startUpCount, bus.loadScore}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.spacePressed = 1'b0;
        bus.onePressed = 1'b0;
        bus.downCountComplete = 1'b0;
        bus.iElapsed = '0;
        repeat (3) @(negedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk); iReset = 1'b1;
        repeat (2) @(negedge clk);

        // Session with averages 300, then 420 with a false start, then 180, then all timeouts.
        sc = '{200, 250, 300, 350, 401};
        startSession(); runTrials(-1); finishSession();
        sc = '{400, 410, 420, 430, 440};
        startSession(); runTrials(2); finishSession();
        sc = '{100, 150, 180, 210, 260};
        startSession(); runTrials(-1); finishSession();
        sc = '{9999, 9999, 10050, 9999, 9999};
        startSession(); runTrials(-1); finishSession();

        // '1' and space together in GO: abort wins, nothing recorded.
        startSession();
        fireDcc();
        check("abort pre GO", 32'(bus.screen), 32'(SCR_GO));
        @(negedge clk); bus.spacePressed = 1'b1; bus.onePressed = 1'b1;
        @(negedge clk); #1;
        check("abort no loadScore", 32'(bus.loadScore), 32'd0);
        bus.spacePressed = 1'b0; bus.onePressed = 1'b0;
        @(negedge clk); #1;
        check("abort screen TITLE", 32'(bus.screen), 32'(SCR_TITLE));
        check("abort trialIndex", 32'(bus.trialIndex), 32'd0);
        check("abort keeps bestAvg", 32'(bus.bestAvg), 32'(expBest));
        $display("abort from GO: screen=%0d", bus.screen);

        // Space edge and delay expiry in the same WAIT cycle: false start.
        startSession();
        @(negedge clk); bus.spacePressed = 1'b1;
        @(negedge clk); bus.downCountComplete = 1'b1; #1;
        check("simul no startUpCount", 32'(bus.startUpCount), 32'd0);
        bus.spacePressed = 1'b0;
        @(negedge clk); bus.downCountComplete = 1'b0; #1;
        check("simul screen FALSE", 32'(bus.screen), 32'(SCR_FALSE));
        @(negedge clk); bus.onePressed = 1'b1;
        @(negedge clk); #1; bus.onePressed = 1'b0;
        @(negedge clk); #1;
        check("one from FALSE", 32'(bus.screen), 32'(SCR_TITLE));
        $display("simultaneous WAIT events: FALSE then TITLE");

        // Asynchronous reset in the middle of the divide, with space held across release.
        sc = '{500, 500, 500, 500, 500};
        startSession(); runTrials(-1);
        repeat (5) @(negedge clk);
        #2;
        bus.spacePressed = 1'b1;
        iReset = 1'b0;
        #1;
        checkAllZero("async reset");
        @(negedge clk); iReset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("held space ignored", 32'(bus.screen), 32'(SCR_TITLE));
        bus.spacePressed = 1'b0;
        @(negedge clk);
        pressSpace();
        check("repress screen WAIT", 32'(bus.screen), 32'(SCR_WAIT));
        check("repress startDownCount", 32'(capDown), 32'd1);
        repeat (25) @(negedge clk);
        #1;
        check("aborted divide avgScore", 32'(bus.avgScore), 32'd0);
        check("aborted divide bestAvg", 32'(bus.bestAvg), 32'd0);
        check("still WAIT", 32'(bus.screen), 32'(SCR_WAIT));
        $display("async reset mid-BUSY: screen=%0d avg=%0d", bus.screen, bus.avgScore);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
